// File: rtl/seq_subtractor_if.sv
// ============================================================================
// Module   : seq_subtractor_if
// Brief    : Operand/result handshake bundle for the sequential subtractor.
//            "master" is the side that issues operands and consumes results;
//            "slave" is the subtractor itself.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_subtractor_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff_out;
  logic         borrow_out;
  logic         zero_out;
  logic         ovf_out;

  modport master (
    output in_valid, a_in, b_in, borrow_in, out_ready,
    input  in_ready, out_valid, diff_out, borrow_out, zero_out, ovf_out
  );

  modport slave (
    input  in_valid, a_in, b_in, borrow_in, out_ready,
    output in_ready, out_valid, diff_out, borrow_out, zero_out, ovf_out
  );
endinterface

`default_nettype wire

// File: rtl/seq_subtractor.sv
// ============================================================================
// Module   : seq_subtractor
// Brief    : Multi-cycle subtractor, diff = a - b - borrow_in. One chunk of
//            DATA_WIDTH bits is processed per cycle, LSB chunk first, with a
//            registered carry (inverted borrow) chained between chunks.
//            One operation in flight; valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_subtractor #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CHUNKS = 4
) (
  input  wire logic      clk_in,
  input  wire logic      rst_in,
  seq_subtractor_if.slave bus
);

  localparam int W     = DATA_WIDTH * NUM_CHUNKS;
  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] C_LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic                 carry_q, carry_d;
  logic [W-1:0]         diff_q, diff_d;
  logic                 borrow_q, borrow_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] w_a_chunk;
  logic [DATA_WIDTH-1:0] w_b_chunk;
  logic [DATA_WIDTH:0]   w_sum;
  logic [W-1:0]          w_diff_ins;

  // Chunk datapath: select the current chunk, add a + ~b + carry and splice
  // the result into the running difference at the current chunk slot.
  always_comb begin
    w_a_chunk  = '0;
    w_b_chunk  = '0;
    w_diff_ins = diff_q;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        w_a_chunk = a_q[i*DATA_WIDTH +: DATA_WIDTH];
        w_b_chunk = b_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    w_sum = {1'b0, w_a_chunk} + {1'b0, ~w_b_chunk} + {{DATA_WIDTH{1'b0}}, carry_q};
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        w_diff_ins[i*DATA_WIDTH +: DATA_WIDTH] = w_sum[DATA_WIDTH-1:0];
      end
    end
  end

  // Next-state and register-update logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          // carry-in of the a + ~b + 1 form; an incoming borrow drops the +1
          carry_d = ~bus.borrow_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        diff_d  = w_diff_ins;
        carry_d = w_sum[DATA_WIDTH];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == C_LAST_CHUNK) begin
          cnt_d    = '0;
          state_d  = S_DONE;
          borrow_d = ~w_sum[DATA_WIDTH];
          zero_d   = (w_diff_ins == '0);
          ovf_d    = (a_q[W-1] != b_q[W-1]) & (w_diff_ins[W-1] != a_q[W-1]);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE) & ~rst_in;
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.diff_out   = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.zero_out   = zero_q;
  assign bus.ovf_out    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_subtractor.sv
// ============================================================================
// Module   : tb_seq_subtractor
// Brief    : Self-checking bench for seq_subtractor: directed corner cases,
//            backpressure, mid-operation reset and randomized operations
//            checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_subtractor;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int W  = DW * NC;

  logic clk_in = 1'b0;
  logic rst_in;
  int   n_vec = 0;
  int   n_err = 0;

  seq_subtractor_if #(.W(W)) bus ();

  seq_subtractor #(
    .DATA_WIDTH(DW),
    .NUM_CHUNKS(NC)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // Single comparison point: counts every check, reports mismatches.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: {ovf, zero, borrow, diff} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bi);
    logic [W:0] u;
    longint     s;
    logic       ovf;
    u   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    s   = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {ovf, (u[W-1:0] == '0), u[W], u[W-1:0]};
  endfunction

  task automatic scramble();
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.a_in      = $urandom;
    bus.b_in      = $urandom;
    bus.borrow_in = 1'($urandom_range(0, 1));
  endtask

  // One full operation: present, accept, wait result, hold for 'hold'
  // cycles with out_ready low while junk is offered, then retire.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input int hold, output logic [W-1:0] got);
    int           cyc;
    logic [W+2:0] e;
    e   = model(a, b, bi);
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk_in);
      cyc++;
    end
    chk("idle_wait", 64'(cyc < 50), 64'd1);
    bus.a_in      = a;
    bus.b_in      = b;
    bus.borrow_in = bi;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    scramble();
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      chk("busy_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk_in);
      scramble();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(NC));
    chk("diff",   64'(bus.diff_out),   64'(e[W-1:0]));
    chk("borrow", 64'(bus.borrow_out), 64'(e[W]));
    chk("zero",   64'(bus.zero_out),   64'(e[W+1]));
    chk("ovf",    64'(bus.ovf_out),    64'(e[W+2]));
    chk("done_ready", 64'(bus.in_ready), 64'd0);
    got = bus.diff_out;
    repeat (hold) begin
      @(negedge clk_in);
      scramble();
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_diff",  64'(bus.diff_out),  64'(e[W-1:0]));
      chk("hold_flags", 64'({bus.ovf_out, bus.zero_out, bus.borrow_out}), 64'(e[W+2:W]));
      chk("hold_ready", 64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk_in);
    bus.out_ready = 1'b0;
    chk("back_idle", 64'({bus.in_ready, bus.out_valid}), 64'b10);
  endtask

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] ra, rb;
    rst_in        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.borrow_in = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    #1;
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) @(negedge clk_in);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_diff",  64'(bus.diff_out),  64'd0);
    chk("rst_flags", 64'({bus.ovf_out, bus.zero_out, bus.borrow_out}), 64'd0);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

    // Directed corner cases
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, got);
    chk("t1_diff", 64'(got), 64'h0000_0002);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, got);
    chk("t2_diff", 64'(got), 64'hFFFF_FFFF);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0, got);
    chk("t3a_diff", 64'(got), 64'h7FFF_FFFF);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, got);
    chk("t3b_diff", 64'(got), 64'h8000_0000);
    run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 0, got);
    chk("t4_diff", 64'(got), 64'h0000_0000);
    // Backpressure with junk offered during DONE, then a fresh op
    run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 3, got);
    run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 0, got);
    chk("t5_fresh", 64'(got), 64'h0000_00FF);

    // Reset during RUN cycle 2
    bus.a_in      = 32'hFFFF_0000;
    bus.b_in      = 32'h0000_FFFF;
    bus.borrow_in = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    bus.in_valid = 1'b0;
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready),  64'd0);
    chk("mid_rst_out",   64'({bus.diff_out, bus.ovf_out, bus.zero_out, bus.borrow_out}), 64'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (8) begin
      @(negedge clk_in);
      chk("no_ghost_valid", 64'(bus.out_valid), 64'd0);
    end
    run_op(32'd10, 32'd20, 1'b0, 0, got);
    chk("t6_diff", 64'(got), 64'hFFFF_FFF6);

    // Randomized operations
    for (int k = 0; k < 150; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = ra;
        1:       rb = ra + 32'd1;
        2:       rb = {~ra[W-1], ra[W-2:0]};
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
